// File: rtl/packetfilter_p3_if.sv
// packetfilter_p3_if: agent-facing signals of the three-buffer packet memory.
// The slave modport is the memory's view; the master modport is the agents' view.
interface packetfilter_p3_if #(
    parameter int PAW = 9,
    parameter int PDW = 64,
    parameter int BAW = 12,
    parameter int INC = 8,
    parameter int PLW = 32
);
    logic [PAW-1:0] sn_addr;
    logic [PDW-1:0] sn_wr_data;
    logic           sn_wr_en;
    logic [INC-1:0] sn_byte_inc;
    logic           sn_done;
    logic           rdy_for_sn;
    logic           rdy_for_sn_ack;
    logic [BAW-1:0] byte_rd_addr;
    logic           cpu_rd_en;
    logic [1:0]     transfer_sz;
    logic [31:0]    resized_mem_data;
    logic           resized_mem_data_vld;
    logic [PLW-1:0] cpu_byte_len;
    logic           cpu_acc;
    logic           cpu_rej;
    logic           rdy_for_cpu;
    logic           rdy_for_cpu_ack;
    logic [PAW-1:0] fwd_addr;
    logic           fwd_rd_en;
    logic [PDW-1:0] fwd_rd_data;
    logic           fwd_rd_data_vld;
    logic [PLW-1:0] fwd_byte_len;
    logic           fwd_done;
    logic           rdy_for_fwd;
    logic           rdy_for_fwd_ack;

    modport slave (
        input  sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn_ack,
               byte_rd_addr, cpu_rd_en, transfer_sz, cpu_acc, cpu_rej, rdy_for_cpu_ack,
               fwd_addr, fwd_rd_en, fwd_done, rdy_for_fwd_ack,
        output rdy_for_sn, resized_mem_data, resized_mem_data_vld, cpu_byte_len, rdy_for_cpu,
               fwd_rd_data, fwd_rd_data_vld, fwd_byte_len, rdy_for_fwd
    );

    modport master (
        output sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn_ack,
               byte_rd_addr, cpu_rd_en, transfer_sz, cpu_acc, cpu_rej, rdy_for_cpu_ack,
               fwd_addr, fwd_rd_en, fwd_done, rdy_for_fwd_ack,
        input  rdy_for_sn, resized_mem_data, resized_mem_data_vld, cpu_byte_len, rdy_for_cpu,
               fwd_rd_data, fwd_rd_data_vld, fwd_byte_len, rdy_for_fwd
    );
endinterface

// File: rtl/packetfilter_p3.sv
// packetfilter_p3: three packet buffers rotating snooper -> CPU -> forwarder/free.
// Words are split into big-endian upper/lower 32-bit banks so an unaligned CPU read fetches two halves in one cycle.
module packetfilter_p3 #(
    parameter int PACKMEM_ADDR_WIDTH  = 9,
    parameter int PACKMEM_DATA_WIDTH  = 64,
    parameter int INTERNAL_ADDR_WIDTH = 10,
    parameter int BYTE_ADDR_WIDTH     = 12,
    parameter int INC_WIDTH           = 8,
    parameter int PLEN_WIDTH          = 32,
    parameter int BUF_IN              = 0,
    parameter int BUF_OUT             = 0,
    parameter int PESS                = 0
) (
    input logic clk,
    input logic rst_n,
    packetfilter_p3_if.slave bus
);
    localparam int PAW = PACKMEM_ADDR_WIDTH;
    localparam int PDW = PACKMEM_DATA_WIDTH;
    localparam int IAW = INTERNAL_ADDR_WIDTH;
    localparam int BAW = BYTE_ADDR_WIDTH;
    localparam int PLW = PLEN_WIDTH;
    localparam int HW  = PDW / 2;

    typedef enum logic [2:0] {FREE, SN, WAIT_CPU, CPU, WAIT_FWD, FWD} bst_e;
    typedef struct packed {logic v; logic [1:0] b; logic [PAW-1:0] ea; logic [PAW-1:0] oa; logic sw; logic [1:0] off; logic [1:0] sz;} creq_t;
    typedef struct packed {logic v; logic [1:0] b; logic [PAW-1:0] a;} freq_t;
    typedef struct packed {logic v; logic [PDW-1:0] win; logic [1:0] off; logic [1:0] sz;} crd_t;
    typedef struct packed {logic v; logic [PDW-1:0] d;} frd_t;
    typedef struct packed {logic v; logic [31:0] d;} cout_t;

    bst_e st_q [3];
    bst_e st_d [3];
    logic [PLW-1:0] len_q [3];
    logic [HW-1:0] hi_mem [3][2**PAW];
    logic [HW-1:0] lo_mem [3][2**PAW];
    logic [5:0] cq_q, fq_q;
    logic [1:0] cq_n_q, fq_n_q;
    logic sn_own, cpu_own, fwd_own, any_free;
    logic [1:0] sn_b, cpu_b, fwd_b, free_b;
    logic sn_clm, sn_wr, sn_fin, cpu_clm, cpu_ok, cpu_no, fwd_clm, fwd_fin;
    logic [IAW-1:0] h;
    logic [PDW-1:0] sh;
    logic [31:0] sel;
    creq_t c0, c1;
    freq_t f0, f1;
    crd_t cr_q, cr2;
    frd_t fr_q, fr2;
    cout_t co0, co;

    // Waiting queues: entry 0 is the oldest buffer; pop shifts down, push lands behind the survivors.
    function automatic logic [5:0] q_next(logic [5:0] q, logic [1:0] n, logic pop, logic push, logic [1:0] b);
        logic [5:0] r;
        logic [1:0] m;
        r = pop ? q >> 2 : q;
        m = n - 2'(pop);
        if (push) r[2*m +: 2] = b;
        return r;
    endfunction

    always_comb begin
        sn_own = 1'b0; cpu_own = 1'b0; fwd_own = 1'b0; any_free = 1'b0;
        sn_b = '0; cpu_b = '0; fwd_b = '0; free_b = '0;
        for (int i = 2; i >= 0; i--) begin
            if (st_q[i] == SN) begin sn_own = 1'b1; sn_b = 2'(i); end
            if (st_q[i] == CPU) begin cpu_own = 1'b1; cpu_b = 2'(i); end
            if (st_q[i] == FWD) begin fwd_own = 1'b1; fwd_b = 2'(i); end
            if (st_q[i] == FREE) begin any_free = 1'b1; free_b = 2'(i); end
        end
    end

    assign bus.rdy_for_sn  = rst_n & ~sn_own & any_free;
    assign bus.rdy_for_cpu = rst_n & ~cpu_own & (cq_n_q != 2'd0);
    assign bus.rdy_for_fwd = rst_n & ~fwd_own & (fq_n_q != 2'd0);
    assign sn_clm  = bus.rdy_for_sn & bus.rdy_for_sn_ack;
    assign sn_wr   = sn_own & bus.sn_wr_en;
    assign sn_fin  = sn_own & bus.sn_done;
    assign cpu_clm = bus.rdy_for_cpu & bus.rdy_for_cpu_ack;
    assign cpu_ok  = cpu_own & bus.cpu_acc;
    assign cpu_no  = cpu_own & bus.cpu_rej & ~bus.cpu_acc;
    assign fwd_clm = bus.rdy_for_fwd & bus.rdy_for_fwd_ack;
    assign fwd_fin = fwd_own & bus.fwd_done;
    assign bus.cpu_byte_len = cpu_own ? len_q[cpu_b] : '0;
    assign bus.fwd_byte_len = fwd_own ? len_q[fwd_b] : '0;

    always_comb begin
        st_d = st_q;
        if (sn_clm) st_d[free_b] = SN;
        if (sn_fin) st_d[sn_b] = WAIT_CPU;
        if (cpu_clm) st_d[cq_q[1:0]] = CPU;
        if (cpu_ok) st_d[cpu_b] = WAIT_FWD;
        if (cpu_no) st_d[cpu_b] = FREE;
        if (fwd_clm) st_d[fq_q[1:0]] = FWD;
        if (fwd_fin) st_d[fwd_b] = FREE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                st_q[i] <= FREE;
                len_q[i] <= '0;
            end
            cq_q <= '0;
            fq_q <= '0;
            cq_n_q <= '0;
            fq_n_q <= '0;
        end else begin
            st_q <= st_d;
            cq_q <= q_next(cq_q, cq_n_q, cpu_clm, sn_fin, sn_b);
            fq_q <= q_next(fq_q, fq_n_q, fwd_clm, cpu_ok, cpu_b);
            cq_n_q <= cq_n_q - 2'(cpu_clm) + 2'(sn_fin);
            fq_n_q <= fq_n_q - 2'(fwd_clm) + 2'(cpu_ok);
            if (sn_clm) len_q[free_b] <= '0;
            if (sn_wr) len_q[sn_b] <= len_q[sn_b] + PLW'(bus.sn_byte_inc);
        end
    end

    always_ff @(posedge clk) begin
        if (sn_wr) begin
            hi_mem[sn_b][bus.sn_addr] <= bus.sn_wr_data[PDW-1:HW];
            lo_mem[sn_b][bus.sn_addr] <= bus.sn_wr_data[HW-1:0];
        end
    end

    // Odd half address h: its own half is the lower bank of word h/2, the next one is the upper bank of word h/2+1.
    assign h  = bus.byte_rd_addr[BAW-1:2];
    assign c0 = '{v: cpu_own & bus.cpu_rd_en, b: cpu_b, ea: h[IAW-1:1] + PAW'(h[0]), oa: h[IAW-1:1],
                  sw: h[0], off: bus.byte_rd_addr[1:0], sz: bus.transfer_sz};
    assign f0 = '{v: fwd_own & bus.fwd_rd_en, b: fwd_b, a: bus.fwd_addr};

    if (BUF_IN != 0) begin : g_in
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c1 <= '0;
                f1 <= '0;
            end else begin
                c1 <= c0;
                f1 <= f0;
            end
        end
    end else begin : g_no_in
        assign c1 = c0;
        assign f1 = f0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_q <= '0;
            fr_q <= '0;
        end else begin
            cr_q.v <= c1.v;
            cr_q.off <= c1.off;
            cr_q.sz <= c1.sz;
            cr_q.win <= c1.sw ? {lo_mem[c1.b][c1.oa], hi_mem[c1.b][c1.ea]} : {hi_mem[c1.b][c1.ea], lo_mem[c1.b][c1.oa]};
            fr_q.v <= f1.v;
            fr_q.d <= {hi_mem[f1.b][f1.a], lo_mem[f1.b][f1.a]};
        end
    end

    if (BUF_OUT != 0) begin : g_out
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cr2 <= '0;
                fr2 <= '0;
            end else begin
                cr2 <= cr_q;
                fr2 <= fr_q;
            end
        end
    end else begin : g_no_out
        assign cr2 = cr_q;
        assign fr2 = fr_q;
    end

    assign sh  = cr2.win << {cr2.off, 3'b000};
    assign sel = sh[PDW-1:PDW-32];
    assign co0 = '{v: cr2.v, d: cr2.sz == 2'b00 ? {24'b0, sel[31:24]} : cr2.sz == 2'b01 ? {16'b0, sel[31:16]} : sel};

    if (PESS != 0) begin : g_pess
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) co <= '0;
            else co <= co0;
        end
    end else begin : g_no_pess
        assign co = co0;
    end

    assign bus.resized_mem_data     = co.d;
    assign bus.resized_mem_data_vld = co.v;
    assign bus.fwd_rd_data          = fr2.d;
    assign bus.fwd_rd_data_vld      = fr2.v;
endmodule

// File: tb/tb_packetfilter_p3.sv
// tb_packetfilter_p3: directed stimulus with read expectations queued for a negedge monitor.
module tb_packetfilter_p3;
    typedef struct {int t; logic [63:0] d;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    exp_t cpu_q[$];
    exp_t fwd_q[$];
    exp_t e;

    logic [11:0] ra [7] = '{12'd3, 12'd1, 12'd6, 12'd7, 12'hffe, 12'hfff, 12'd7};
    logic [1:0]  rs [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [31:0] re [7] = '{32'h33, 32'h1122, 32'h66778899, 32'h778899aa, 32'hf00d0011, 32'h0d, 32'h7788};

    packetfilter_p3_if #(.PAW(9), .PDW(64), .BAW(12), .INC(8), .PLW(32)) bus ();
    packetfilter_p3 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.sn_addr = '0; bus.sn_wr_data = '0; bus.sn_wr_en = 0; bus.sn_byte_inc = '0; bus.sn_done = 0;
        bus.rdy_for_sn_ack = 0; bus.byte_rd_addr = '0; bus.cpu_rd_en = 0; bus.transfer_sz = '0;
        bus.cpu_acc = 0; bus.cpu_rej = 0; bus.rdy_for_cpu_ack = 0; bus.fwd_addr = '0; bus.fwd_rd_en = 0;
        bus.fwd_done = 0; bus.rdy_for_fwd_ack = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sn_wr(logic [8:0] a, logic [63:0] d, logic [7:0] inc, logic done);
        bus.sn_addr = a; bus.sn_wr_data = d; bus.sn_byte_inc = inc; bus.sn_wr_en = 1; bus.sn_done = done;
        tick();
    endtask

    task automatic cpu_rd(logic [11:0] a, logic [1:0] sz, logic [31:0] d);
        bus.byte_rd_addr = a; bus.transfer_sz = sz; bus.cpu_rd_en = 1;
        cpu_q.push_back('{cyc + 1, {32'h0, d}});
        tick();
    endtask

    task automatic fwd_rd(logic [8:0] a, logic [63:0] d);
        bus.fwd_addr = a; bus.fwd_rd_en = 1;
        fwd_q.push_back('{cyc + 1, d});
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.resized_mem_data_vld) begin
            if (cpu_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL cpu_vld: got unexpected %0h want no data", bus.resized_mem_data);
            end else begin
                e = cpu_q.pop_front();
                chk("cpu_data", {32'h0, bus.resized_mem_data}, e.d);
                chk("cpu_lat", cyc, e.t);
            end
        end
        if (rst_n && bus.fwd_rd_data_vld) begin
            if (fwd_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL fwd_vld: got unexpected %0h want no data", bus.fwd_rd_data);
            end else begin
                e = fwd_q.pop_front();
                chk("fwd_data", bus.fwd_rd_data, e.d);
                chk("fwd_lat", cyc, e.t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy_sn", bus.rdy_for_sn, 0);
        chk("rst_data", bus.resized_mem_data, 0);
        rst_n = 1;
        #1;
        chk("rel_rdy_sn", bus.rdy_for_sn, 1);
        chk("rel_rdy_cpu", bus.rdy_for_cpu, 0);
        chk("rel_rdy_fwd", bus.rdy_for_fwd, 0);
        chk("rel_cpu_len", bus.cpu_byte_len, 0);
        // packet A: length 5+0+3 with the last write in the sn_done cycle
        bus.rdy_for_sn_ack = 1; tick();
        chk("sn_own_rdy", bus.rdy_for_sn, 0);
        sn_wr(9'd0, 64'h0011223344556677, 8'd5, 0);
        sn_wr(9'd511, 64'hdeadbeefcafef00d, 8'd0, 0);
        sn_wr(9'd1, 64'h8899aabbccddeeff, 8'd3, 1);
        chk("a_rdy_cpu", bus.rdy_for_cpu, 1);
        chk("a_rdy_sn", bus.rdy_for_sn, 1);
        bus.rdy_for_cpu_ack = 1; tick();
        chk("a_cpu_len", bus.cpu_byte_len, 8);
        chk("a_rdy_cpu_drop", bus.rdy_for_cpu, 0);
        for (int i = 0; i < 7; i++) cpu_rd(ra[i], rs[i], re[i]);
        repeat (3) tick();
        bus.cpu_acc = 1; tick();
        chk("a_rdy_fwd", bus.rdy_for_fwd, 1);
        chk("a_cpu_len_0", bus.cpu_byte_len, 0);
        bus.cpu_rd_en = 1; tick();
        bus.rdy_for_fwd_ack = 1; tick();
        chk("a_fwd_len", bus.fwd_byte_len, 8);
        fwd_rd(9'd0, 64'h0011223344556677);
        fwd_rd(9'd1, 64'h8899aabbccddeeff);
        fwd_rd(9'd511, 64'hdeadbeefcafef00d);
        repeat (3) tick();
        bus.fwd_done = 1; tick();
        chk("a_fwd_done_rdy", bus.rdy_for_fwd, 0);
        chk("a_fwd_len_0", bus.fwd_byte_len, 0);
        // three packets queued for the CPU, lengths 1,2,3, first byte = packet number
        for (int k = 1; k <= 3; k++) begin
            bus.rdy_for_sn_ack = 1; tick();
            sn_wr(9'd0, {8{8'(k)}}, 8'(k), 1);
        end
        chk("full_rdy_sn", bus.rdy_for_sn, 0);
        chk("full_rdy_cpu", bus.rdy_for_cpu, 1);
        bus.rdy_for_sn_ack = 1; tick();
        chk("full_ack_ignored", bus.rdy_for_sn, 0);
        bus.rdy_for_cpu_ack = 1; tick();
        chk("p1_len", bus.cpu_byte_len, 1);
        bus.cpu_rej = 1; tick();
        chk("rej_rdy_sn", bus.rdy_for_sn, 1);
        bus.rdy_for_cpu_ack = 1; tick();
        chk("p2_len", bus.cpu_byte_len, 2);
        cpu_rd(12'd0, 2'b00, 32'h02);
        repeat (2) tick();
        bus.cpu_acc = 1; bus.rdy_for_sn_ack = 1; tick();
        chk("sim_rdy_fwd", bus.rdy_for_fwd, 1);
        chk("sim_rdy_sn", bus.rdy_for_sn, 0);
        bus.rdy_for_cpu_ack = 1; bus.rdy_for_fwd_ack = 1; tick();
        chk("p3_len", bus.cpu_byte_len, 3);
        chk("p2_fwd_len", bus.fwd_byte_len, 2);
        bus.cpu_acc = 1; bus.cpu_rej = 1; tick();
        chk("accrej_rdy_fwd", bus.rdy_for_fwd, 0);
        bus.fwd_done = 1; tick();
        chk("acc_wins", bus.rdy_for_fwd, 1);
        bus.rdy_for_fwd_ack = 1; tick();
        chk("p3_fwd_len", bus.fwd_byte_len, 3);
        // reset in the middle of a write and a forwarder read
        bus.sn_wr_en = 1; bus.sn_byte_inc = 8'd4; bus.fwd_rd_en = 1;
        rst_n = 0;
        #1;
        chk("mid_rdy_sn", bus.rdy_for_sn, 0);
        chk("mid_rdy_cpu", bus.rdy_for_cpu, 0);
        chk("mid_rdy_fwd", bus.rdy_for_fwd, 0);
        chk("mid_fwd_len", bus.fwd_byte_len, 0);
        chk("mid_fwd_vld", bus.fwd_rd_data_vld, 0);
        chk("mid_cpu_vld", bus.resized_mem_data_vld, 0);
        repeat (2) tick();
        rst_n = 1;
        #1;
        chk("rel2_rdy_sn", bus.rdy_for_sn, 1);
        chk("rel2_rdy_cpu", bus.rdy_for_cpu, 0);
        chk("rel2_rdy_fwd", bus.rdy_for_fwd, 0);
        repeat (3) tick();
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("fwd_q_drained", fwd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
